// File: rtl/noc_inject_buf_if.sv
// noc_inject_buf_if
//   Flit bus used on both sides of the injection buffer: a flit with its
//   virtual channel and valid bit travels downstream, and a per-VC ready
//   vector travels upstream.
//
//   Signals:
//     data  [DATAW:0]  flit payload
//     valid            flit present on data
//     vch   [VCHW:0]   virtual channel of the flit
//     rdy   [VCH:0]    per-VC ready from the receiver
//
//   Modports:
//     master  drives data/valid/vch, samples rdy  (flit producer)
//     slave   samples data/valid/vch, drives rdy  (flit consumer)
interface noc_inject_buf_if #(
  parameter int DATAW = 7,
  parameter int VCHW  = 0,
  parameter int VCH   = 1
);
  logic [DATAW:0] data;
  logic           valid;
  logic [VCHW:0]  vch;
  logic [VCH:0]   rdy;

  modport master (output data, valid, vch, input rdy);
  modport slave  (input data, valid, vch, output rdy);
endinterface

// File: rtl/noc_inject_buf.sv
// noc_inject_buf
//   Injection buffer between a PE transmit side and the local input port of
//   its router. Incoming flits are sorted into one circular FIFO per virtual
//   channel; a round-robin arbiter forwards buffered flits to the router on
//   the VCs the router marks ready. The router must take every flit offered
//   with valid high; its per-VC ready is the only backpressure.
//
//   Ports:
//     clk   in   clock, all state updates on the rising edge
//     rst_  in   asynchronous, active-high reset
//     pe    slave side of noc_inject_buf_if: flit/valid/vch from the PE,
//           rdy = per-VC "not full" back to the PE
//     rtr   master side of noc_inject_buf_if: registered flit/valid/vch to
//           the router, rdy = per-VC ready from the router
//     ovf   out  sticky overflow flag
//
//   Build option:
//     INJ_OVF_DET_EN  when defined, a push attempt into a full VC sets the
//                     sticky ovf flag; when undefined, ovf is tied to 0.
//                     The offending flit is dropped in both builds.
module noc_inject_buf #(
  parameter int DEPTH = 4,
  parameter int DATAW = 7,
  parameter int VCHW  = 0,
  parameter int VCH   = 1
) (
  input  logic             clk,
  input  logic             rst_,
  noc_inject_buf_if.slave  pe,
  noc_inject_buf_if.master rtr,
  output logic             ovf
);

  localparam int NVC  = VCH + 1;
  localparam int VW   = VCHW + 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] PTR_MAX  = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [DATAW:0]  mem  [NVC][DEPTH];
  logic [PTRW-1:0] rptr [NVC];
  logic [PTRW-1:0] wptr [NVC];
  logic [CNTW-1:0] cnt  [NVC];
  logic            last;

  logic [NVC-1:0]  push_v;
  logic [NVC-1:0]  pop_v;
  logic [NVC-1:0]  elig;
  logic            gnt_any;
  logic [VW-1:0]   gnt_vc;

  // Per-VC status. Readiness and eligibility come from the registered
  // count only, so a flit pushed into an empty VC cannot be granted in the
  // same cycle and pe.rdy never depends on pe.valid.
  always_comb begin
    push_v = '0;
    elig   = '0;
    pe.rdy = '0;
    for (int v = 0; v < NVC; v++) begin
      pe.rdy[v] = (cnt[v] != CNT_FULL);
      elig[v]   = (cnt[v] != '0) && rtr.rdy[v];
      push_v[v] = pe.valid && (cnt[v] != CNT_FULL) && (pe.vch == VW'(v));
    end
  end

  // Two-VC round robin: when both are eligible the one not served last
  // wins, otherwise the only eligible VC wins.
  always_comb begin
    gnt_any = |elig;
    gnt_vc  = '0;
    pop_v   = '0;
    if (elig[0] && elig[1]) begin
      gnt_vc = VW'(~last);
    end else if (elig[1]) begin
      gnt_vc = VW'(1);
    end
    if (gnt_any) begin
      pop_v[gnt_vc] = 1'b1;
    end
  end

  // Flit storage carries no reset; only the pointers/counts decide what is
  // valid, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NVC; v++) begin
      if (push_v[v]) begin
        mem[v][wptr[v]] <= pe.data;
      end
    end
  end

  // Pointers, counts, arbiter history and the registered router outputs.
  // A simultaneous push and pop on one VC advances both pointers and
  // leaves its count unchanged.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int v = 0; v < NVC; v++) begin
        rptr[v] <= '0;
        wptr[v] <= '0;
        cnt[v]  <= '0;
      end
      last      <= 1'b1;
      rtr.data  <= '0;
      rtr.valid <= 1'b0;
      rtr.vch   <= '0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (push_v[v]) begin
          wptr[v] <= (wptr[v] == PTR_MAX) ? '0 : wptr[v] + PTRW'(1);
        end
        if (pop_v[v]) begin
          rptr[v] <= (rptr[v] == PTR_MAX) ? '0 : rptr[v] + PTRW'(1);
        end
        if (push_v[v] && !pop_v[v]) begin
          cnt[v] <= cnt[v] + CNTW'(1);
        end else if (!push_v[v] && pop_v[v]) begin
          cnt[v] <= cnt[v] - CNTW'(1);
        end
      end
      rtr.valid <= gnt_any;
      if (gnt_any) begin
        rtr.data <= mem[gnt_vc][rptr[gnt_vc]];
        rtr.vch  <= gnt_vc;
        last     <= gnt_vc[0];
      end
    end
  end

`ifdef INJ_OVF_DET_EN
  logic ovf_q;

  // Sticky flag for a push attempted into a full VC; cleared only by reset.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      ovf_q <= 1'b0;
    end else if (pe.valid && !pe.rdy[pe.vch]) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_noc_inject_buf.sv
// tb_noc_inject_buf
//   Self-checking bench for noc_inject_buf. A queue-per-VC reference model
//   predicts every output after each clock edge from the stimulus applied
//   before it; directed phases are followed by a randomized run.
module tb_noc_inject_buf;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_;
  logic ovf;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model: one queue per VC plus the last-served VC.
  logic [7:0] mq [2][$];
  bit         mlast;
  bit         exp_valid;
  logic [7:0] exp_data;
  bit         exp_vch;
  bit         exp_ovf;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  noc_inject_buf_if pe_if ();
  noc_inject_buf_if rtr_if ();

  noc_inject_buf #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .pe   (pe_if.slave),
    .rtr  (rtr_if.master),
    .ovf  (ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq[0].delete();
    mq[1].delete();
    mlast     = 1'b1;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_vch   = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  task automatic checkAll();
    logic [1:0] exp_rdy;
    exp_rdy = {mq[1].size() != DEPTH, mq[0].size() != DEPTH};
    checkOutput({phase, "/ovalid"}, 32'(rtr_if.valid), 32'(exp_valid));
    checkOutput({phase, "/odata"},  32'(rtr_if.data),  32'(exp_data));
    checkOutput({phase, "/ovch"},   32'(rtr_if.vch),   32'(exp_vch));
    checkOutput({phase, "/pe_rdy"}, 32'(pe_if.rdy),    32'(exp_rdy));
    checkOutput({phase, "/ovf"},    32'(ovf),          32'(exp_ovf));
  endtask

  // Drive one cycle of stimulus, advance the model across the coming edge,
  // then compare every output just after that edge.
  task automatic applyStimulus(input bit valid, input bit vch, input logic [7:0] data,
                               input logic [1:0] ordy);
    int sz [2];
    bit el [2];
    bit g;
    pe_if.valid = valid;
    pe_if.vch   = vch;
    pe_if.data  = data;
    rtr_if.rdy  = ordy;
    sz[0] = mq[0].size();
    sz[1] = mq[1].size();
    el[0] = (sz[0] != 0) && ordy[0];
    el[1] = (sz[1] != 0) && ordy[1];
    if (el[0] && el[1]) g = ~mlast;
    else                g = el[1];
    if (el[0] || el[1]) begin
      exp_valid = 1'b1;
      exp_data  = mq[g].pop_front();
      exp_vch   = g;
      mlast     = g;
    end else begin
      exp_valid = 1'b0;
    end
    if (valid) begin
      if (sz[vch] != DEPTH) begin
        mq[vch].push_back(data);
      end else begin
`ifdef INJ_OVF_DET_EN
        exp_ovf = 1'b1;
`endif
      end
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    pe_if.valid = 1'b0;
    pe_if.vch   = 1'b0;
    pe_if.data  = '0;
    rtr_if.rdy  = 2'b00;
    rst_        = 1'b1;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    checkAll();
    rst_ = 1'b0;

    phase = "single";
    applyStimulus(1'b1, 1'b1, 8'h5A, 2'b11);
    applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    checkOutput("single/flit", 32'({rtr_if.valid, rtr_if.vch, rtr_if.data}), 32'h35A);
    applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);
    checkOutput("single/idle", 32'(rtr_if.valid), 32'd0);

    phase = "fill";
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'(8'h10 + i), 2'b10);
    checkOutput("fill/rdy_full", 32'(pe_if.rdy), 32'b10);
    phase = "overflow";
    applyStimulus(1'b1, 1'b0, 8'hEE, 2'b10);
    phase = "drain";
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);

    phase = "fair";
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h20 + i), 2'b00);
      applyStimulus(1'b1, 1'b1, 8'(8'h30 + i), 2'b00);
    end
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);

    phase = "pushpop";
    applyStimulus(1'b1, 1'b1, 8'h40, 2'b00);
    applyStimulus(1'b1, 1'b1, 8'h41, 2'b00);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(8'h50 + i), 2'b10);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);

    phase = "midreset";
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 2'b00);
    pe_if.valid = 1'b0;
    rtr_if.rdy  = 2'b11;
    #2;
    rst_ = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    phase = "postreset";
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 2'($urandom));
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
